risc0_uart_fifo: RTL
====================

// Module: risc0_uart_fifo
// PURPOSE
//  Parametrised buffered UART for the RISC0 FPGA host/status link. TX and RX paths each carry a FIFO.
//  Baud rate is set at runtime through a divisor port. RX uses 16x oversampling with start-bit glitch
//  rejection, and reports sticky framing and overrun errors. Sits between the top-level status logic and the board pins.
// PARAMETERS
//  DIV_W      16  width of baud_div
//  DATA_BITS  8   data bits per frame, legal 5..8, sent LSB first
//  FIFO_DEPTH 16  entries per FIFO, power of two, >=2
//  LVL_W      $clog2(FIFO_DEPTH+1)  derived width of the level outputs
// PORTS
//  clk           in   1          sole clock
//  rst           in   1          synchronous, active-high reset
//  baud_div      in   DIV_W      tick period minus 1; one tick = baud_div+1 clk cycles; one bit = 16 ticks
//  tx_data       in   DATA_BITS  byte to transmit
//  tx_valid      in   1          tx_data valid
//  tx_ready      out  1          TX FIFO can accept
//  rx_data       out  DATA_BITS  head of RX FIFO (first-word fall-through)
//  rx_valid      out  1          RX FIFO non-empty
//  rx_ready      in   1          consumer pops head
//  err_clr       in   1          clears all sticky error flags
//  rx_frame_err  out  1          sticky: stop bit sampled 0
//  rx_overrun    out  1          sticky: byte received while RX FIFO full
//  tx_level      out  LVL_W      TX FIFO occupancy
//  rx_level      out  LVL_W      RX FIFO occupancy
//  uart_tx       out  1          serial out, idles high
//  uart_rx       in   1          serial in, asynchronous
// BEHAVIOUR
//  Clocking/reset: one clock; reset is synchronous and active-high.
//  Reset values: uart_tx=1, tx_ready=1, rx_valid=0, rx_data=0, both levels=0, errors=0, FSMs IDLE, tick counter=0.
//  Reset mid-frame aborts the frame immediately and empties both FIFOs.
//  Tick gen: free-running counter 0..baud_div; tick pulses when count>=baud_div, then count reloads 0.
//   baud_div=0 gives a tick every cycle. A baud_div change takes effect at the next compare.
//  Handshakes: a transfer occurs when valid&&ready are high on a rising edge. tx_ready=!tx_full.
//   A full TX FIFO rejects a push even if the FSM pops in the same cycle.
//   Simultaneous push+pop on a non-full, non-empty FIFO leaves level unchanged.
//  TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   In IDLE with FIFO non-empty, the FSM pops on the next tick and enters START.
//   uart_tx is registered. START drives 0, DATA drives bits LSB first, STOP drives 1.
//   Each state lasts exactly 16 ticks. Back-to-back bytes leave no idle gap after STOP.
//  RX sync: uart_rx passes a 2-flop synchroniser; all RX logic uses the synchronised value.
//  RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: a 0 sampled on a tick enters START with sub-count 0.
//   START: at sub-count 7 (mid-bit) re-sample. If 1, glitch: back to IDLE, nothing logged.
//   DATA: sample every 16 ticks from mid-start for DATA_BITS bits.
//   STOP: sample at mid-bit.
//    1 -> push byte. If FIFO full: byte dropped, rx_overrun set, FIFO contents untouched.
//    0 -> byte discarded, rx_frame_err set. FSM waits for line=1 before returning to IDLE (break handling).
//  Errors: sticky until err_clr. If a set and err_clr land in the same cycle, the set wins.
//  Latency: accepted TX byte -> start bit within 1 tick + 2 clk when TX FSM idle.
//   RX stop-bit mid-sample -> rx_valid high 1 clk later.
// CONFIGURATION
//  RISC0_UART_PARITY_EN defined:
//   adds PARAMETER PARITY_ODD (default 0, even) and output rx_parity_err (sticky, cleared by err_clr).
//   TX inserts a PARITY state: 1 bit, XOR of data bits (inverted if PARITY_ODD).
//   RX checks parity. On mismatch the byte is discarded and rx_parity_err set; frame-error rules still apply.
//  Undefined: no PARITY states; frame = 1 start + DATA_BITS + 1 stop; rx_parity_err port absent.
// TESTING
//  1 baud_div=0, push 0xA5 -> uart_tx = 0 (start), then data 1,0,1,0,0,1,0,1, then 1 (stop).
//    Each level lasts 16 clk; tx_level returns to 0.
//  2 Loopback uart_tx->uart_rx, baud_div=3, push 0x00..0x0F back-to-back with rx_ready=0
//    -> rx_level=16, rx_data pops 0x00..0x0F in order, no errors.
//  3 Loopback, DEPTH=16, 17 bytes, rx_ready=0 -> rx_level=16, rx_overrun=1, first pop 0x00.
//    err_clr -> rx_overrun=0.
//  4 Drive a frame 0x3C with stop bit=0 -> rx_frame_err=1, rx_level stays 0.
//    A following good frame 0x55 is received correctly.
//  5 baud_div=3, 3-clk low pulse on uart_rx -> no push, no error, RX FSM back in IDLE.
//  6 Assert rst mid-DATA of a TX frame with 5 bytes queued -> next cycle uart_tx=1, tx_level=0, tx_ready=1.
//    With RISC0_UART_PARITY_EN: 0x07 even -> parity bit 1; flipped parity on RX -> rx_parity_err=1.

Source files
------------

// File: rtl/risc0_uart_fifo.sv
// risc0_uart_fifo: buffered UART with runtime baud divisor, 16x RX oversampling and TX/RX FIFOs.
// Optional parity: define RISC0_UART_PARITY_EN to add PARITY_ODD and the rx_parity_err output.

module risc0_uart_fifo_buf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // A full FIFO refuses a push even when a pop happens in the same cycle.
   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = empty ? '0 : mem[rd_ptr];

   // NOTE: the storage array is deliberately not reset; only pointers and level
   // carry state that matters, and a reset-free array can map onto RAM.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)      level <= level + 1'b1;
         else if (pop_ok && !push_ok) level <= level - 1'b1;
      end
   end
endmodule

module risc0_uart_fifo #(
   parameter int DIV_W      = 16,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
`ifdef RISC0_UART_PARITY_EN
   parameter bit PARITY_ODD = 1'b0,
`endif
   parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   input  logic                 err_clr,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
`ifdef RISC0_UART_PARITY_EN
   output logic                 rx_parity_err,
`endif
   output logic [LVL_W-1:0]     tx_level,
   output logic [LVL_W-1:0]     rx_level,
   output logic                 uart_tx,
   input  logic                 uart_rx
);
   localparam int BIT_W = 3;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

   logic [DIV_W-1:0] tick_cnt;
   logic             tick;

   assign tick = (tick_cnt >= baud_div);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (rst || tick) tick_cnt <= '0;
      else             tick_cnt <= tick_cnt + 1'b1;
   end

   // ---------------- TX path ----------------
   state_t               tx_state;
   logic [3:0]           tx_sub;
   logic [BIT_W-1:0]     tx_bit;
   logic [DATA_BITS-1:0] tx_shift;
   logic [DATA_BITS-1:0] tx_head;
   logic                 tx_full;
   logic                 tx_empty;
   logic                 tx_pop;
`ifdef RISC0_UART_PARITY_EN
   logic                 tx_par;
`endif

   assign tx_ready = !tx_full;

   risc0_uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_valid),
      .wdata (tx_data),
      .pop   (tx_pop),
      .rdata (tx_head),
      .full  (tx_full),
      .empty (tx_empty),
      .level (tx_level)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      tx_pop = 1'b0;
      if (tick && !tx_empty)
         tx_pop = (tx_state == S_IDLE) || (tx_state == S_STOP && tx_sub == 4'd15);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx_sub   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         uart_tx  <= 1'b1;
`ifdef RISC0_UART_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else if (tx_pop) begin
         tx_state <= S_START;
         tx_sub   <= '0;
         tx_shift <= tx_head;
         uart_tx  <= 1'b0;
`ifdef RISC0_UART_PARITY_EN
         tx_par   <= PARITY_ODD ^ (^tx_head);
`endif
      end else if (tick) begin
         if (tx_sub != 4'd15) begin
            tx_sub <= tx_sub + 1'b1;
         end else begin
            tx_sub <= '0;
            case (tx_state)
               S_START: begin
                  tx_state <= S_DATA;
                  tx_bit   <= '0;
                  uart_tx  <= tx_shift[0];
               end
               S_DATA: begin
                  if (tx_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef RISC0_UART_PARITY_EN
                     tx_state <= S_PARITY;
                     uart_tx  <= tx_par;
`else
                     tx_state <= S_STOP;
                     uart_tx  <= 1'b1;
`endif
                  end else begin
                     tx_bit   <= tx_bit + 1'b1;
                     tx_shift <= tx_shift >> 1;
                     uart_tx  <= tx_shift[1];
                  end
               end
               S_PARITY: begin
                  tx_state <= S_STOP;
                  uart_tx  <= 1'b1;
               end
               default: begin
                  tx_state <= S_IDLE;
                  uart_tx  <= 1'b1;
               end
            endcase
         end
      end
   end

   // ---------------- RX path ----------------
   logic                 rx_meta;
   logic                 rx_sync;
   state_t               rx_state;
   logic [3:0]           rx_sub;
   logic [BIT_W-1:0]     rx_bit;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 rx_mid;
   logic                 rx_push;
   logic                 rx_full;
   logic                 rx_empty;
   logic                 frame_set;
   logic                 overrun_set;
`ifdef RISC0_UART_PARITY_EN
   logic                 rx_par_bad;
   logic                 par_set;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
      end
   end

   // Start bit is re-sampled 8 ticks in; every later bit 16 ticks after that.
   always_comb begin
      rx_mid    = 1'b0;
      rx_push   = 1'b0;
      frame_set = 1'b0;
`ifdef RISC0_UART_PARITY_EN
      par_set   = 1'b0;
`endif
      if (tick) rx_mid = (rx_state == S_START) ? (rx_sub == 4'd7) : (rx_sub == 4'd15);
      if (rx_mid && rx_state == S_STOP) begin
`ifdef RISC0_UART_PARITY_EN
         if (rx_sync) rx_push = !rx_par_bad;
`else
         if (rx_sync) rx_push = 1'b1;
`endif
         else         frame_set = 1'b1;
      end
`ifdef RISC0_UART_PARITY_EN
      if (rx_mid && rx_state == S_PARITY) par_set = rx_sync ^ PARITY_ODD ^ (^rx_shift);
`endif
   end

   assign overrun_set = rx_push && rx_full;
   assign rx_valid    = !rx_empty;

   risc0_uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .wdata (rx_shift),
      .pop   (rx_ready),
      .rdata (rx_data),
      .full  (rx_full),
      .empty (rx_empty),
      .level (rx_level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state   <= S_IDLE;
         rx_sub     <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
`ifdef RISC0_UART_PARITY_EN
         rx_par_bad <= 1'b0;
`endif
      end else begin
         case (rx_state)
            S_IDLE: begin
               if (tick && !rx_sync) begin
                  rx_state <= S_START;
                  rx_sub   <= '0;
               end
            end
            S_BREAK: begin
               if (rx_sync) rx_state <= S_IDLE;
            end
            default: begin
               if (tick && !rx_mid) begin
                  rx_sub <= rx_sub + 1'b1;
               end else if (rx_mid) begin
                  rx_sub <= '0;
                  case (rx_state)
                     S_START: begin
                        if (rx_sync) rx_state <= S_IDLE;
                        else begin
                           rx_state <= S_DATA;
                           rx_bit   <= '0;
                        end
                     end
                     S_DATA: begin
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef RISC0_UART_PARITY_EN
                           rx_state <= S_PARITY;
`else
                           rx_state <= S_STOP;
`endif
                        end else begin
                           rx_bit <= rx_bit + 1'b1;
                        end
                     end
                     S_PARITY: begin
`ifdef RISC0_UART_PARITY_EN
                        rx_par_bad <= par_set;
`endif
                        rx_state <= S_STOP;
                     end
                     S_STOP: rx_state <= rx_sync ? S_IDLE : S_BREAK;
                     default: rx_state <= S_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   // A new error event in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_frame_err  <= 1'b0;
         rx_overrun    <= 1'b0;
`ifdef RISC0_UART_PARITY_EN
         rx_parity_err <= 1'b0;
`endif
      end else begin
         rx_frame_err  <= frame_set   | (rx_frame_err  & !err_clr);
         rx_overrun    <= overrun_set | (rx_overrun    & !err_clr);
`ifdef RISC0_UART_PARITY_EN
         rx_parity_err <= par_set     | (rx_parity_err & !err_clr);
`endif
      end
   end
endmodule
